// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters access to a shared memory bus.
// Optional XFER watchdog is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     rq,
    input  logic [NREQ-1:0]     start,
    input  logic [2*NREQ-1:0]   mode_in,
    input  logic [8*NREQ-1:0]   addr_in,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rdy,
    output logic                mem_rq,
    output logic                mem_start,
    output logic [1:0]          mem_mode,
    output logic [7:0]          mem_addr,
    input  logic                mem_gnt,
    input  logic                mem_rdy,
    output logic                timeout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("bus_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MREQ = 3'd1,
        GNT  = 3'd2,
        XFER = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   owner_inc;
    logic            first_q;
    logic            abort;
    logic [NREQ-1:0] own_hot;
    logic [1:0]      sel_mode;
    logic [7:0]      sel_addr;

    assign own_hot   = {{(NREQ-1){1'b0}}, 1'b1} << owner;
    assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // First set request at or above ptr, wrapping at NREQ.
    always_comb begin
        int  idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && rq[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_mode = '0;
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                sel_mode = mode_in[2*i +: 2];
                sel_addr = addr_in[8*i +: 8];
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       timeout_q;

    assign abort   = (state == XFER) && !mem_rdy && (wd_cnt == 8'(TIMEOUT - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= abort;
            if (state == GNT && state_nxt == XFER)
                wd_cnt <= '0;
            else if (state == XFER)
                wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (|rq) begin
                    owner_nxt = pick;
                    state_nxt = MREQ;
                end
            end
            MREQ: begin
                if (!rq[owner])
                    state_nxt = IDLE;
                else if (mem_gnt)
                    state_nxt = GNT;
            end
            GNT: begin
                if (!rq[owner])
                    state_nxt = IDLE;
                else if (start[owner])
                    state_nxt = XFER;
            end
            XFER: begin
                if (mem_rdy) begin
                    state_nxt = DONE;
                end else if (abort) begin
                    ptr_nxt   = owner_inc;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                ptr_nxt   = owner_inc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            first_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            first_q <= (state == GNT) && (state_nxt == XFER);
        end
    end

    always_comb begin
        gnt       = '0;
        rdy       = '0;
        mem_rq    = 1'b0;
        mem_start = 1'b0;
        mem_mode  = '0;
        mem_addr  = '0;
        unique case (state)
            MREQ: begin
                mem_rq   = 1'b1;
                mem_mode = sel_mode;
                mem_addr = sel_addr;
            end
            GNT: begin
                mem_rq   = 1'b1;
                gnt      = own_hot;
                mem_mode = sel_mode;
                mem_addr = sel_addr;
            end
            XFER: begin
                mem_rq    = 1'b1;
                gnt       = own_hot;
                mem_start = first_q;
                mem_mode  = sel_mode;
                mem_addr  = sel_addr;
            end
            DONE:    rdy = own_hot;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: a transaction-level model picks the owner and
// predicts each cycle's outputs from the request/handshake timeline it drives.
module tb_bus_arbiter;

    localparam int N   = 4;
    localparam int TMO = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   rq, start;
    logic [2*N-1:0] mode_in;
    logic [8*N-1:0] addr_in;
    logic [N-1:0]   gnt, rdy;
    logic           mem_rq, mem_start, mem_gnt, mem_rdy, timeout;
    logic [1:0]     mem_mode;
    logic [7:0]     mem_addr;

    int checks = 0;
    int errors = 0;
    int ptr     = 0;
    bit tmo_exp = 1'b0;
    bit rand_data = 1'b1;

    always #5 clk = ~clk;

    bus_arbiter #(.NREQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rq(rq), .start(start),
        .mode_in(mode_in), .addr_in(addr_in),
        .gnt(gnt), .rdy(rdy), .mem_rq(mem_rq), .mem_start(mem_start),
        .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rdy(mem_rdy), .timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] e_gnt, input logic [N-1:0] e_rdy,
                           input logic e_mrq, input logic e_mst, input logic [1:0] e_mode,
                           input logic [7:0] e_addr, input logic e_tmo);
        check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
        check({tag, ".rdy"},       32'(rdy),       32'(e_rdy));
        check({tag, ".mem_rq"},    32'(mem_rq),    32'(e_mrq));
        check({tag, ".mem_start"}, 32'(mem_start), 32'(e_mst));
        check({tag, ".mem_mode"},  32'(mem_mode),  32'(e_mode));
        check({tag, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
        check({tag, ".timeout"},   32'(timeout),   32'(e_tmo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester at or after ptr, wrapping.
    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // ab: 0 normal, 1 drop rq in last MREQ cycle, 2 drop rq in last GNT cycle, 3 reset in first XFER cycle
    task automatic xact(input logic [N-1:0] rqv, input int gw, input int sw, input int rw, input int ab);
        int         o;
        logic [N-1:0] oh;
        logic [1:0] em;
        logic [7:0] ea;
        int         c;
        bit         fin, aborted;

        if (rand_data) begin
            mode_in = {N{2'($urandom)}} ^ 2*N'($urandom);
            addr_in = {$urandom, $urandom};
        end
        rq = rqv; start = N'($urandom); mem_gnt = 1'($urandom); mem_rdy = 1'b0;
        #1;
        chk_out("idle", '0, '0, 0, 0, 2'd0, 8'd0, tmo_exp);
        tmo_exp = 1'b0;
        if (rqv == '0) begin
            tick();
            return;
        end
        o  = model_pick(rqv);
        oh = N'(1) << o;
        em = 2'(mode_in >> (2 * o));
        ea = 8'(addr_in >> (8 * o));
        tick();

        for (c = 0; c <= gw; c++) begin
            rq = N'($urandom) | oh; start = N'($urandom); mem_gnt = (c == gw);
            if (ab == 1 && c == gw) rq[o] = 1'b0;
            #1;
            chk_out("mreq", '0, '0, 1, 0, em, ea, 0);
            tick();
            if (ab == 1 && c == gw) return;
        end

        for (c = 0; c <= sw; c++) begin
            rq = N'($urandom) | oh; mem_gnt = 1'($urandom);
            start = N'($urandom) & ~oh;
            if (c == sw) start[o] = 1'b1;
            if (ab == 2 && c == sw) rq[o] = 1'b0;
            #1;
            chk_out("gnt", oh, '0, 1, 0, em, ea, 0);
            tick();
            if (ab == 2 && c == sw) return;
        end

        c = 0; fin = 1'b0; aborted = 1'b0;
        while (!fin) begin
            rq = N'($urandom); start = N'($urandom); mem_gnt = 1'($urandom);
            mem_rdy = (ab == 3) ? 1'b0 : (c == rw);
            if (ab == 3) rst = 1'b1;
            #1;
            chk_out("xfer", oh, '0, 1, (c == 0), em, ea, 0);
            tick();
            if (ab == 3) begin
                rst = 1'b0; mem_rdy = 1'b0;
                #1;
                chk_out("rst", '0, '0, 0, 0, 2'd0, 8'd0, 0);
                ptr = 0; tmo_exp = 1'b0;
                return;
            end
            if (c == rw) fin = 1'b1;
            else if (TMO_EN && c == TMO - 1) begin
                aborted = 1'b1; fin = 1'b1;
            end
            c++;
        end
        mem_rdy = 1'b0;
        if (aborted) begin
            ptr = (o + 1) % N;
            tmo_exp = 1'b1;
            return;
        end

        rq = N'($urandom); start = N'($urandom);
        #1;
        chk_out("done", '0, oh, 0, 0, 2'd0, 8'd0, 0);
        ptr = (o + 1) % N;
        tick();
    endtask

    initial begin
        rst = 1'b1; rq = '0; start = '0; mode_in = '0; addr_in = '0;
        mem_gnt = 1'b0; mem_rdy = 1'b0;
        tick(); tick();
        chk_out("reset", '0, '0, 0, 0, 2'd0, 8'd0, 0);
        rst = 1'b0;

        // Round robin with all requests held: owners 0,1,2,3,0
        for (int i = 0; i < 5; i++) xact(4'b1111, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0);

        // Single requester, zero wait states
        xact(4'b0001, 0, 0, 0, 0);

        // Address/mode mux for requester 2
        rand_data = 1'b0;
        mode_in = 8'b00_10_00_00;
        addr_in = 32'h00A5_0000;
        xact(4'b0100, 1, 1, 1, 0);
        rand_data = 1'b1;

        // Abandon in GNT and in MREQ, then confirm ptr unchanged
        xact(4'b0010, 1, 1, 0, 2);
        xact(4'b1111, 0, 0, 0, 0);
        xact(4'b1010, 0, 0, 0, 1);
        xact(4'b1111, 0, 0, 0, 0);

        // Watchdog boundary: mem_rdy in last counted cycle, then never
        xact(4'b1111, 0, 0, TMO - 1, 0);
        xact(4'b1111, 0, 0, TMO + 6, 0);
        xact(4'b0000, 0, 0, 0, 0);

        // Reset mid-XFER, next grant goes to requester 0
        xact(4'b1110, 0, 0, 0, 3);
        xact(4'b1111, 0, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            int r, ab;
            r  = $urandom_range(0, 9);
            ab = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            xact(N'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6), ab);
        end
        xact(4'b0000, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
